plru_way_selector: RTL and testbench
====================================

Name: plru_way_selector

Overview:
- Upstream stage of the cache's one-hot output mux: generates the one-hot way select that steers the hot set to the Cache output.
- Keeps tree pseudo-LRU state per set. On a hit it forwards the hit way; on a miss it picks the PLRU victim. Either way it updates the tree so the accessed way becomes MRU.
- Output is registered, with a valid/ready handshake, and can drive the mux select directly.

Parameters:
- numWays, 4, ways per set; power of 2, at least 2; tree holds numWays-1 bits per set.
- numSets, 16, number of sets; power of 2, at least 2.
- setBits, $clog2(numSets), derived width of the set index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  pulse; re-initialise all PLRU state.
- init_done  output  1  high once the init sweep completes.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when valid and ready are both high.
- req_set  input  setBits  set index.
- req_hit  input  1  1 = hit, 0 = miss.
- req_hit_way  input  [0:numWays-1]  one-hot hit way; bit i = way i.
- resp_valid  output  1  resp_way valid.
- resp_ready  input  1  downstream consumes the response.
- resp_way  output  [0:numWays-1]  one-hot way select; same bit order as the mux sel.
- resp_miss  output  1  1 = resp_way is a victim, 0 = a hit way.

Behaviour:
- Tree storage:
  - Array tree[numSets][numWays-1], no reset (LUTRAM-friendly); cleared by the init sweep.
  - Heap indexing: node 0 is the root; children of node n are 2n+1 and 2n+2.
  - Node bit 0 = victim in the left (lower-index) half; bit 1 = victim in the right half.
- Victim: walk from the root following the node bits; the leaf reached is the way.
- Update on access to way w: each node on w's path is set to point away from w.
- FSM states: INIT, RUN, DRAIN.
- Reset:
  - Go to INIT with init_cnt=0.
  - resp_valid=0, resp_way=0, resp_miss=0, init_done=0, req_ready=0.
  - Reset mid-operation drops any pending response and restarts the sweep.
- INIT:
  - Each cycle write tree[init_cnt] = all zero and increment init_cnt.
  - After writing set numSets-1, go to RUN; init_done=1 from the next cycle.
  - Sweep takes exactly numSets cycles.
- RUN:
  - req_ready = !resp_valid || resp_ready (single output register).
  - On accept, at the same edge: load resp_way and resp_miss, set resp_valid=1, write the updated tree for req_set.
  - Latency is 1 cycle from accept to resp_valid.
  - Hit: resp_way = req_hit_way, resp_miss=0.
  - Miss: resp_way = one-hot victim computed from tree[req_set] before the update, resp_miss=1.
  - Back-to-back requests to the same set see the updated bits, with no stall.
  - Accepting while resp_valid && resp_ready: the new response replaces the old one with no bubble (full throughput).
  - resp_ready low with resp_valid high: hold resp_way and resp_miss stable, req_ready=0.
  - resp_valid && resp_ready with no new request: resp_valid drops to 0 next cycle.
- DRAIN:
  - flush seen in RUN with resp_valid=1 goes to DRAIN; req_ready=0.
  - Once the response has been consumed, go to INIT.
  - flush with resp_valid=0 goes directly to INIT. If a request is accepted in that same cycle, its response is issued first; then DRAIN, then INIT.
  - init_done drops to 0 whenever INIT is entered.
- Non-one-hot req_hit_way with req_hit=1: handling depends on the optional feature below.

Optional Feature:
- Macro: PLRU_ONEHOT_CHECK_EN.
- Defined:
  - Adds output port err_onehot (1 bit): sticky, cleared only by reset.
  - A hit with req_hit_way not exactly one-hot (zero or multi-bit) is handled as a miss: victim response, resp_miss=1.
  - Sets err_onehot the cycle after accept.
- Undefined:
  - Port err_onehot absent.
  - A non-one-hot hit way is priority-encoded to its lowest set bit; zero encodes to way 0.
  - resp_way is always exactly one-hot.

Decomposition:
- Package plru_pkg:
  - State enum type (INIT, RUN, DRAIN).
  - Function victim_of(tree bits) returning a way index.
  - Function update_of(tree bits, way) returning new tree bits.
  - Function onehot2idx, and a one-hot-check helper.
- One natural sub-module, plru_tree_logic: purely combinational. Takes the current tree bits and the access way and produces victim one-hot plus next tree bits; wrapped by the FSM and storage.

Test Plan (numWays=4, numSets=16):
- Reset, hold req_valid=1 -> req_ready=0 for 16 cycles; init_done=1 on cycle 17; no response during INIT.
- Four misses to set 3, resp_ready=1 -> resp_way selects ways 0, 2, 1, 3 in order; resp_miss=1; each 1 cycle after accept, no bubbles.
- Continue: hit way 0 on set 3, then miss on set 3 -> first resp_way = way 0 with resp_miss=0; second = way 2.
- Miss set 5 with resp_ready=0 for 3 cycles -> resp_valid held, resp_way = way 0 stable, req_ready=0; a second request is accepted the cycle resp_ready rises.
- flush while a response is pending -> DRAIN until consumed, then 16-cycle INIT; afterwards a miss to set 3 returns way 0.
- PLRU_ONEHOT_CHECK_EN: hit with req_hit_way = ways 1 and 2 both set on a fresh set -> response selects way 0, resp_miss=1, err_onehot=1 and stays 1 until reset. Without the macro -> way 1, resp_miss=0.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and tree helpers for the pseudo-LRU way selector.
// The helpers work on fixed-width containers sized for the largest supported
// configuration (64 ways); callers zero-extend their tree and pass the real
// tree depth as lvls.
package plru_pkg;

    localparam int MAX_WAYS = 64;
    localparam int MAX_LVLS = 6;

    typedef logic [MAX_WAYS-2:0] tree_t;
    typedef logic [MAX_WAYS-1:0] ways_t;
    typedef logic [5:0]          idx_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Walk from the root following the node bits; return the leaf index reached.
    function automatic idx_t victim_of(input tree_t bits, input int lvls);
        logic [6:0] n;
        n = '0;
        for (int l = 0; l < MAX_LVLS; l++) begin
            if (l < lvls) begin
                n = bits[n[5:0]] ? (n << 1) + 7'd2 : (n << 1) + 7'd1;
            end
        end
        return idx_t'(n - 7'((1 << lvls) - 1));
    endfunction

    // Point every node on the path to 'way' at the opposite subtree.
    function automatic tree_t update_of(input tree_t bits, input idx_t way, input int lvls);
        tree_t      r;
        logic [6:0] n;
        idx_t       sh;
        r = bits;
        n = '0;
        for (int l = 0; l < MAX_LVLS; l++) begin
            if (l < lvls) begin
                sh           = way >> (lvls - 1 - l);
                r[n[5:0]]    = ~sh[0];
                n            = sh[0] ? (n << 1) + 7'd2 : (n << 1) + 7'd1;
            end
        end
        return r;
    endfunction

    // Lowest set bit wins; an all-zero vector encodes to way 0.
    function automatic idx_t onehot2idx(input ways_t v);
        idx_t r;
        r = '0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (v[i]) r = idx_t'(i);
        end
        return r;
    endfunction

    function automatic logic is_onehot(input ways_t v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            c = c + int'(v[i]);
        end
        return (c == 1);
    endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU core: from one set's tree bits and the access kind,
// produce the selected way (hit way or victim) as a one-hot and the next tree.
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter int numWays = 4
) (
    input  logic [numWays-2:0]         cur_bits,
    input  logic                       use_hit,
    input  logic [$clog2(numWays)-1:0] hit_idx,
    output logic [numWays-1:0]         way_oh,
    output logic [numWays-2:0]         next_bits
);

    localparam int WB = $clog2(numWays);
    localparam int NB = numWays - 1;

    tree_t         bits_ext;
    logic [WB-1:0] vict;
    logic [WB-1:0] acc_idx;

    // Victim is taken from the pre-update bits; the accessed way becomes MRU.
    always_comb begin
        bits_ext               = '0;
        bits_ext[numWays-2:0]  = cur_bits;
        vict                   = WB'(victim_of(bits_ext, WB));
        acc_idx                = use_hit ? hit_idx : vict;
        next_bits              = NB'(update_of(bits_ext, idx_t'(acc_idx), WB));
        way_oh                 = '0;
        way_oh[acc_idx]        = 1'b1;
    end

endmodule

// File: rtl/plru_way_selector.sv
// Per-set tree pseudo-LRU way selector feeding a one-hot output mux.
// Hit requests forward the hit way, misses get the PLRU victim; the accessed
// way is made MRU. Registered response with valid/ready handshake.
// Optional macro PLRU_ONEHOT_CHECK_EN: treat non-one-hot hit ways as misses
// and flag them on a sticky err_onehot output.
module plru_way_selector
    import plru_pkg::*;
#(
    parameter int numWays = 4,
    parameter int numSets = 16,
    parameter int setBits = $clog2(numSets)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    output logic               init_done,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [setBits-1:0] req_set,
    input  logic               req_hit,
    input  logic [0:numWays-1] req_hit_way,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [0:numWays-1] resp_way,
`ifdef PLRU_ONEHOT_CHECK_EN
    output logic               err_onehot,
`endif
    output logic               resp_miss
);

    localparam int WB = $clog2(numWays);

    state_t              state_q, state_d;
    logic [setBits-1:0]  init_cnt;
    logic                acc;
    logic                use_hit;
    ways_t               hv;
    logic [WB-1:0]       hit_idx;
    logic [numWays-2:0]  tree [numSets];
    logic [numWays-2:0]  cur_bits;
    logic [numWays-2:0]  next_bits;
    logic [numWays-1:0]  way_oh;
`ifdef PLRU_ONEHOT_CHECK_EN
    logic                bad_hit;
`endif

    assign req_ready = (state_q == RUN) && (!resp_valid || resp_ready);
    assign acc       = req_valid && req_ready;
    assign cur_bits  = tree[req_set];

    // Decode the hit way into an index and decide whether it is honoured.
    always_comb begin
        hv = '0;
        for (int i = 0; i < numWays; i++) begin
            hv[i] = req_hit_way[i];
        end
        hit_idx = WB'(onehot2idx(hv));
`ifdef PLRU_ONEHOT_CHECK_EN
        bad_hit = req_hit && !is_onehot(hv);
        use_hit = req_hit && !bad_hit;
`else
        use_hit = req_hit;
`endif
    end

    plru_tree_logic #(
        .numWays (numWays)
    ) u_tree_logic (
        .cur_bits  (cur_bits),
        .use_hit   (use_hit),
        .hit_idx   (hit_idx),
        .way_oh    (way_oh),
        .next_bits (next_bits)
    );

    // Tree storage: zeroed by the init sweep, updated on every accepted request.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            tree[init_cnt] <= '0;
        end else if (acc) begin
            tree[req_set] <= next_bits;
        end
    end

    // State register, sweep counter and init_done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_cnt  <= (state_q == INIT) ? init_cnt + 1'b1 : '0;
            init_done <= (state_d != INIT);
        end
    end

    // Next-state: a pending or just-accepted response must drain before INIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: begin
                if (init_cnt == setBits'(numSets - 1)) state_d = RUN;
            end
            RUN: begin
                if (flush) state_d = (resp_valid || acc) ? DRAIN : INIT;
            end
            DRAIN: begin
                if (!resp_valid || resp_ready) state_d = INIT;
            end
            default: state_d = INIT;
        endcase
    end

    // Single output register: load on accept, clear valid once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_way   <= '0;
            resp_miss  <= 1'b0;
        end else if (acc) begin
            resp_valid <= 1'b1;
            resp_miss  <= !use_hit;
            for (int i = 0; i < numWays; i++) begin
                resp_way[i] <= way_oh[i];
            end
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef PLRU_ONEHOT_CHECK_EN
    // Sticky flag for malformed hit ways; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_onehot <= 1'b0;
        end else if (acc && bad_hit) begin
            err_onehot <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_plru_way_selector.sv
// Directed testbench for plru_way_selector (numWays=4, numSets=16).
// Honours PLRU_ONEHOT_CHECK_EN for the err_onehot port and malformed-hit case.
module tb_plru_way_selector;

    localparam logic [0:3] W0 = 4'b1000;
    localparam logic [0:3] W1 = 4'b0100;
    localparam logic [0:3] W2 = 4'b0010;
    localparam logic [0:3] W3 = 4'b0001;
    localparam logic [0:3] WZ = 4'b0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       init_done;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_set;
    logic       req_hit;
    logic [0:3] req_hit_way;
    logic       resp_valid;
    logic       resp_ready;
    logic [0:3] resp_way;
    logic       resp_miss;
`ifdef PLRU_ONEHOT_CHECK_EN
    logic       err_onehot;
`endif

    int n_chk = 0;
    int n_err = 0;

    plru_way_selector #(
        .numWays (4),
        .numSets (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .init_done   (init_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_set     (req_set),
        .req_hit     (req_hit),
        .req_hit_way (req_hit_way),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_way    (resp_way),
`ifdef PLRU_ONEHOT_CHECK_EN
        .err_onehot  (err_onehot),
`endif
        .resp_miss   (resp_miss)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [0:3] obs, input logic [0:3] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:3] exp4 [4];
        exp4[0] = W0; exp4[1] = W2; exp4[2] = W1; exp4[3] = W3;

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_set = 4'd0;
        req_hit = 1'b0; req_hit_way = WZ; resp_ready = 1'b1;
        tick();
        tick();
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chkw("rst_resp_way",   resp_way,   WZ);
        chk1("rst_resp_miss",  resp_miss,  1'b0);
        chk1("rst_init_done",  init_done,  1'b0);
        chk1("rst_req_ready",  req_ready,  1'b0);
`ifdef PLRU_ONEHOT_CHECK_EN
        chk1("rst_err_onehot", err_onehot, 1'b0);
`endif

        // Sweep with a request held: nothing may be accepted for 16 cycles.
        reset = 1'b0; req_valid = 1'b1; req_set = 4'd3; req_hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk1("init_req_ready",  req_ready,  1'b0);
            chk1("init_done_low",   init_done,  1'b0);
            chk1("init_resp_valid", resp_valid, 1'b0);
            tick();
        end
        chk1("init_done_high", init_done, 1'b1);
        chk1("run_req_ready",  req_ready, 1'b1);

        // Four back-to-back misses to set 3.
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("miss4_valid", resp_valid, 1'b1);
            chkw("miss4_way",   resp_way,   exp4[k]);
            chk1("miss4_miss",  resp_miss,  1'b1);
        end

        // Hit way 0, then a miss sees the updated tree.
        req_hit = 1'b1; req_hit_way = W0;
        tick();
        chkw("hit0_way",  resp_way,  W0);
        chk1("hit0_miss", resp_miss, 1'b0);
        req_hit = 1'b0;
        tick();
        chkw("after_hit_way",  resp_way,  W2);
        chk1("after_hit_miss", resp_miss, 1'b1);

        // Backpressure on set 5.
        req_set = 4'd5;
        tick();
        chkw("s5_way", resp_way, W0);
        resp_ready = 1'b0;
        #1;
        chk1("bp_req_ready", req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("bp_valid",     resp_valid, 1'b1);
            chkw("bp_way",       resp_way,   W0);
            chk1("bp_miss",      resp_miss,  1'b1);
            chk1("bp_req_ready", req_ready,  1'b0);
        end
        resp_ready = 1'b1;
        #1;
        chk1("bp_release_ready", req_ready, 1'b1);
        tick();
        chkw("s5_second_way", resp_way,   W2);
        chk1("s5_second_vld", resp_valid, 1'b1);

        // Flush with a response pending: DRAIN until consumed.
        req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("drain_req_ready", req_ready,  1'b0);
        chk1("drain_valid",     resp_valid, 1'b1);
        chkw("drain_way",       resp_way,   W2);
        tick();
        chk1("drain_hold", resp_valid, 1'b1);
        resp_ready = 1'b1;
        tick();
        chk1("drain_consumed", resp_valid, 1'b0);
        chk1("reinit_done",    init_done,  1'b0);
        req_valid = 1'b1; req_set = 4'd3; req_hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk1("reinit_req_ready", req_ready, 1'b0);
            tick();
        end
        chk1("reinit_done_high", init_done, 1'b1);
        tick();
        chkw("post_flush_way",  resp_way,   W0);
        chk1("post_flush_miss", resp_miss,  1'b1);
        req_valid = 1'b0;
        tick();
        chk1("valid_drop", resp_valid, 1'b0);

        // Flush in the same cycle as an accept with no response pending.
        req_valid = 1'b1; flush = 1'b1;
        #1;
        chk1("flush_acc_ready", req_ready, 1'b1);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk1("flush_acc_valid", resp_valid, 1'b1);
        chkw("flush_acc_way",   resp_way,   W2);
        chk1("flush_acc_drain", req_ready,  1'b0);
        tick();
        chk1("flush_acc_init",  init_done,  1'b0);
        chk1("flush_acc_empty", resp_valid, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        chk1("flush_acc_run", init_done, 1'b1);

        // Hit with two ways set on a fresh set.
        req_valid = 1'b1; req_set = 4'd9; req_hit = 1'b1; req_hit_way = 4'b0110;
        tick();
        req_valid = 1'b0; req_hit = 1'b0;
`ifdef PLRU_ONEHOT_CHECK_EN
        chkw("multi_way",  resp_way,  W0);
        chk1("multi_miss", resp_miss, 1'b1);
`else
        chkw("multi_way",  resp_way,  W1);
        chk1("multi_miss", resp_miss, 1'b0);
`endif
        tick();
        chk1("multi_drop", resp_valid, 1'b0);
`ifdef PLRU_ONEHOT_CHECK_EN
        chk1("err_set", err_onehot, 1'b1);
        tick();
        tick();
        chk1("err_sticky", err_onehot, 1'b1);
`endif

        // Reset from RUN clears everything again.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("rst2_valid",     resp_valid, 1'b0);
        chk1("rst2_init_done", init_done,  1'b0);
        chk1("rst2_req_ready", req_ready,  1'b0);
`ifdef PLRU_ONEHOT_CHECK_EN
        chk1("rst2_err", err_onehot, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
